// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the debounced input PIO: register map, reset patterns
// and elaboration-time parameter checks.
package soc_system_pio_pkg;

   localparam int unsigned BUS_W  = 32;
   localparam int unsigned ADDR_W = 3;

   localparam logic [ADDR_W-1:0] ADDR_DATA = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_RAW  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_EDGE = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_RISE = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ADDR_FALL = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] ADDR_DBNC = ADDR_W'(6);

   // FALL_EN comes out of reset all ones so the block acts like the legacy falling-edge PIO
   function automatic logic [BUS_W-1:0] fall_en_reset(input int unsigned width);
      logic [BUS_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < BUS_W; i++) begin
         if (i < width) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic bit params_legal(input int unsigned width,
                                       input int unsigned sync_stages,
                                       input int unsigned db_w,
                                       input int unsigned db_default);
      bit ok;
      ok = (width >= 1) && (width <= 32) && (sync_stages >= 2) &&
           (db_w >= 1) && (db_w <= 32);
      if (ok && (db_w < 32)) ok = ((db_default >> db_w) == 0);
      return ok;
   endfunction

endpackage

// File: rtl/soc_system_pio_debounced_in_if.sv
// Avalon-MM slave bus of the debounced input PIO.
interface soc_system_pio_debounced_in_if;
   import soc_system_pio_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [BUS_W-1:0]  writedata;
   logic [BUS_W-1:0]  readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/soc_system_pio_debounce_chan.sv
// One input channel: synchroniser chain followed by a saturating debounce counter.
module soc_system_pio_debounce_chan #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_W        = 20
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_bit,
   input  logic [DB_W-1:0] ticks,
   output logic            raw,
   output logic            stable,
   output logic            upd
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_stable;
   logic [DB_W-1:0]        r_cnt;
   logic [DB_W:0]          w_cnt_inc;
   logic [DB_W:0]          w_limit;
   logic                   w_differ;

   always_ff @(posedge clk or negedge reset_n) begin : p_sync
      if (!reset_n) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], in_bit};
   end

   assign raw      = r_sync[SYNC_STAGES-1];
   assign stable   = r_stable;
   assign w_differ = (raw != r_stable);

   // A programmed period of zero behaves as one; the extra bit keeps the compare exact
   assign w_cnt_inc = {1'b0, r_cnt} + (DB_W+1)'(1);
   assign w_limit   = (ticks == '0) ? (DB_W+1)'(1) : {1'b0, ticks};
   assign upd       = w_differ && (w_cnt_inc >= w_limit);

   always_ff @(posedge clk or negedge reset_n) begin : p_debounce
      if (!reset_n) begin
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else if (!w_differ) begin
         r_cnt <= '0;
      end else if (upd) begin
         r_stable <= raw;
         r_cnt    <= '0;
      end else begin
         r_cnt <= w_cnt_inc[DB_W-1:0];
      end
   end

endmodule

// File: rtl/soc_system_pio_debounced_in.sv
// Avalon-MM input PIO with per-channel debouncing, edge selection and lossless
// edge capture driving a single level interrupt.
module soc_system_pio_debounced_in
   import soc_system_pio_pkg::*;
#(
   parameter int unsigned WIDTH       = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_W        = 20,
   parameter int unsigned DB_DEFAULT  = 50000
) (
   input  logic                          clk,
   input  logic                          reset_n,
   soc_system_pio_debounced_in_if.slave  bus,
   input  logic [WIDTH-1:0]              in_port,
   output logic                          irq
);

   if (!params_legal(WIDTH, SYNC_STAGES, DB_W, DB_DEFAULT)) begin : g_bad_params
      $error("soc_system_pio_debounced_in: illegal parameter combination");
   end

   localparam logic [WIDTH-1:0] FALL_RST = WIDTH'(fall_en_reset(WIDTH));

   logic [WIDTH-1:0] r_mask, r_edge, r_rise, r_fall;
   logic [DB_W-1:0]  r_dbnc;
   logic [BUS_W-1:0] r_readdata;
   logic [WIDTH-1:0] w_raw, w_stable, w_upd, w_ev, w_clr, w_wdata;
   logic [BUS_W-1:0] w_rdata;
   logic             w_wr;
   logic             w_unused;

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      soc_system_pio_debounce_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_W        (DB_W)
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .in_bit  (in_port[g]),
         .ticks   (r_dbnc),
         .raw     (w_raw[g]),
         .stable  (w_stable[g]),
         .upd     (w_upd[g])
      );
   end

   assign w_wr     = bus.chipselect && !bus.write_n;
   assign w_wdata  = bus.writedata[WIDTH-1:0];
   assign w_unused = ^bus.writedata;

   // Edge event uses the value being committed to stable on this update
   assign w_ev  = w_upd & ((r_rise & w_raw) | (r_fall & ~w_raw));
   assign w_clr = (w_wr && (bus.address == ADDR_EDGE)) ? w_wdata : '0;

   always_comb begin : p_rmux
      w_rdata = '0;
      case (bus.address)
         ADDR_DATA: w_rdata = BUS_W'(w_stable);
         ADDR_RAW:  w_rdata = BUS_W'(w_raw);
         ADDR_MASK: w_rdata = BUS_W'(r_mask);
         ADDR_EDGE: w_rdata = BUS_W'(r_edge);
         ADDR_RISE: w_rdata = BUS_W'(r_rise);
         ADDR_FALL: w_rdata = BUS_W'(r_fall);
         ADDR_DBNC: w_rdata = BUS_W'(r_dbnc);
         default:   w_rdata = '0;
      endcase
   end

   // Capture applies clear before set so an event on the clear edge is kept
   always_ff @(posedge clk or negedge reset_n) begin : p_regs
      if (!reset_n) begin
         r_mask     <= '0;
         r_edge     <= '0;
         r_rise     <= '0;
         r_fall     <= FALL_RST;
         r_dbnc     <= DB_W'(DB_DEFAULT);
         r_readdata <= '0;
      end else begin
         r_readdata <= w_rdata;
         r_edge     <= (r_edge & ~w_clr) | w_ev;
         if (w_wr) begin
            case (bus.address)
               ADDR_MASK: r_mask <= w_wdata;
               ADDR_RISE: r_rise <= w_wdata;
               ADDR_FALL: r_fall <= w_wdata;
               ADDR_DBNC: r_dbnc <= bus.writedata[DB_W-1:0];
               default:   ;
            endcase
         end
      end
   end

   assign bus.readdata = r_readdata;
   assign irq          = |(r_edge & r_mask);

endmodule
